cache_refill_ctrl: RTL and testbench

- Miss-handling stage directly upstream of the direct-mapped data cache (4 sets, 4-word lines, 32-bit words).
- On a load that misses, it stalls the pipeline and fetches the whole line from backing data memory, one word per transaction.
- It then presents the assembled line on d0..d3 with a one-cycle fill strobe, so the cache can write it and replay the access.

---
 rtl/cache_pkg.sv | 29 ++
 rtl/cache_refill_ctrl.sv | 162 ++++++++++++++++
 tb/tb_cache_refill_ctrl.sv | 299 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/cache_pkg.sv
// Shared definitions for the direct-mapped data cache and its refill controller.
// Address split (byte address): [1:0] byte, [3:2] word in line, [5:4] set, [31:6] tag.
package cache_pkg;

  localparam int DATA_W       = 32;
  localparam int LINE_WORDS_C = 4;

  localparam int WORD_OFF_LSB = 2;
  localparam int LINE_OFF_MSB = 3;
  localparam int SET_LSB      = 4;
  localparam int SET_BITS     = 2;
  localparam int TAG_LSB      = 6;
  localparam int TAG_BITS     = 26;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    WAIT = 2'd2,
    FILL = 2'd3
  } refill_state_t;

  typedef logic [LINE_WORDS_C-1:0][DATA_W-1:0] line_t;

  // Slot addressed by the refill: fetch-order offset plus running counter, wrapping at 4.
  function automatic logic [1:0] word_idx_f(input logic [1:0] off, input logic [1:0] cnt);
    return off + cnt;
  endfunction

endpackage

// File: rtl/cache_refill_ctrl.sv
// Cache miss refill controller: on a load miss it stalls the pipeline, reads the
// whole 4-word line from data memory one word at a time, then strobes the
// assembled line out on d0..d3 for one cycle.
// Optional build macro: CACHE_CRITICAL_WORD_FIRST_EN -- fetch starts at the
// missing word and the first returned word is forwarded on early_valid/early_data.
module cache_refill_ctrl
  import cache_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 32,
  parameter int LINE_WORDS = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req_valid,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  input  logic                  req_hit,
  output logic                  stall,
  output logic                  busy,
  output logic                  mem_rd_en,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  input  logic [DATA_WIDTH-1:0] mem_rdata,
  input  logic                  mem_rvalid,
  output logic                  fill_valid,
  output logic [ADDR_WIDTH-1:0] fill_addr,
`ifdef CACHE_CRITICAL_WORD_FIRST_EN
  output logic                  early_valid,
  output logic [DATA_WIDTH-1:0] early_data,
`endif
  output logic [DATA_WIDTH-1:0] d0,
  output logic [DATA_WIDTH-1:0] d1,
  output logic [DATA_WIDTH-1:0] d2,
  output logic [DATA_WIDTH-1:0] d3
);

  refill_state_t                 state_q;
  logic [1:0]                    cnt_q;
  logic [1:0]                    off_q;
  logic [ADDR_WIDTH-1:SET_LSB]   base_q;
  logic [DATA_WIDTH-1:0]         buf_q  [LINE_WORDS];
  logic [DATA_WIDTH-1:0]         line_q [LINE_WORDS];
  logic                          mem_rd_en_q;
  logic [ADDR_WIDTH-1:0]         mem_addr_q;
  logic                          fill_valid_q;
  logic [ADDR_WIDTH-1:0]         fill_addr_q;
`ifdef CACHE_CRITICAL_WORD_FIRST_EN
  logic                          early_valid_q;
  logic [DATA_WIDTH-1:0]         early_data_q;
`endif

  logic                          miss_s;
  logic [1:0]                    first_idx_s;
  logic [1:0]                    word_idx_s;
  logic [1:0]                    next_idx_s;
  logic [LINE_OFF_MSB:0]         unused_addr_s;

  assign miss_s        = req_valid & ~req_hit;
  assign unused_addr_s = req_addr[LINE_OFF_MSB:0];

`ifdef CACHE_CRITICAL_WORD_FIRST_EN
  assign first_idx_s = req_addr[LINE_OFF_MSB:WORD_OFF_LSB];
`else
  assign first_idx_s = 2'b00;
`endif

  assign word_idx_s = word_idx_f(off_q, cnt_q);
  assign next_idx_s = word_idx_f(off_q, cnt_q + 2'd1);

  // Refill FSM: counter, line buffer and all registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      cnt_q        <= 2'd0;
      off_q        <= 2'd0;
      base_q       <= '0;
      mem_rd_en_q  <= 1'b0;
      mem_addr_q   <= '0;
      fill_valid_q <= 1'b0;
      fill_addr_q  <= '0;
      for (int k = 0; k < LINE_WORDS; k++) begin
        buf_q[k]  <= '0;
        line_q[k] <= '0;
      end
`ifdef CACHE_CRITICAL_WORD_FIRST_EN
      early_valid_q <= 1'b0;
      early_data_q  <= '0;
`endif
    end else begin
      // Strobes are single-cycle unless re-armed below.
      mem_rd_en_q  <= 1'b0;
      fill_valid_q <= 1'b0;
`ifdef CACHE_CRITICAL_WORD_FIRST_EN
      early_valid_q <= 1'b0;
`endif
      case (state_q)
        IDLE: begin
          if (miss_s) begin
            base_q      <= req_addr[ADDR_WIDTH-1:SET_LSB];
            off_q       <= first_idx_s;
            cnt_q       <= 2'd0;
            mem_rd_en_q <= 1'b1;
            mem_addr_q  <= {req_addr[ADDR_WIDTH-1:SET_LSB], first_idx_s, 2'b00};
            state_q     <= REQ;
          end
        end
        REQ: begin
          // The read request is on the bus this cycle; any rvalid now is stale.
          state_q <= WAIT;
        end
        WAIT: begin
          if (mem_rvalid) begin
            buf_q[word_idx_s] <= mem_rdata;
`ifdef CACHE_CRITICAL_WORD_FIRST_EN
            if (cnt_q == 2'd0) begin
              early_valid_q <= 1'b1;
              early_data_q  <= mem_rdata;
            end
`endif
            if (cnt_q == 2'd3) begin
              // Publish the complete line; outputs keep it until the next fill.
              for (int k = 0; k < LINE_WORDS; k++) begin
                line_q[k] <= (word_idx_s == 2'(k)) ? mem_rdata : buf_q[k];
              end
              fill_addr_q  <= {base_q, 4'b0000};
              fill_valid_q <= 1'b1;
              state_q      <= FILL;
            end else begin
              cnt_q       <= cnt_q + 2'd1;
              mem_rd_en_q <= 1'b1;
              mem_addr_q  <= {base_q, next_idx_s, 2'b00};
              state_q     <= REQ;
            end
          end
        end
        FILL: begin
          cnt_q   <= 2'd0;
          state_q <= IDLE;
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  // The combinational miss term stalls the pipeline in the detect cycle itself.
  assign stall      = (state_q != IDLE) | miss_s;
  assign busy       = (state_q != IDLE);
  assign mem_rd_en  = mem_rd_en_q;
  assign mem_addr   = mem_addr_q;
  assign fill_valid = fill_valid_q;
  assign fill_addr  = fill_addr_q;
  assign d0         = line_q[0];
  assign d1         = line_q[1];
  assign d2         = line_q[2];
  assign d3         = line_q[3];
`ifdef CACHE_CRITICAL_WORD_FIRST_EN
  assign early_valid = early_valid_q;
  assign early_data  = early_data_q;
`endif

endmodule

// File: tb/tb_cache_refill_ctrl.sv
// Directed testbench for cache_refill_ctrl (default build, ordered word fetch).
module tb_cache_refill_ctrl;

  logic        clk;
  logic        rst;
  logic        req_valid;
  logic [31:0] req_addr;
  logic        req_hit;
  logic        stall;
  logic        busy;
  logic        mem_rd_en;
  logic [31:0] mem_addr;
  logic [31:0] mem_rdata;
  logic        mem_rvalid;
  logic        fill_valid;
  logic [31:0] fill_addr;
  logic [31:0] d0, d1, d2, d3;

  int checks;
  int failures;

  // Memory responder settings
  int          mem_lat;
  bit          spur_en;
  logic [31:0] mem_dbase;
  logic [31:0] rd_log[$];

  cache_refill_ctrl #(
    .DATA_WIDTH(32),
    .ADDR_WIDTH(32),
    .LINE_WORDS(4)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_addr  (req_addr),
    .req_hit   (req_hit),
    .stall     (stall),
    .busy      (busy),
    .mem_rd_en (mem_rd_en),
    .mem_addr  (mem_addr),
    .mem_rdata (mem_rdata),
    .mem_rvalid(mem_rvalid),
    .fill_valid(fill_valid),
    .fill_addr (fill_addr),
    .d0        (d0),
    .d1        (d1),
    .d2        (d2),
    .d3        (d3)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Data memory: answers each read mem_lat cycles later with mem_dbase + word index.
  initial begin
    int          pend_cnt;
    bit          pend;
    logic [31:0] pend_addr;
    pend = 1'b0;
    pend_cnt = 0;
    pend_addr = 32'h0;
    mem_rvalid = 1'b0;
    mem_rdata = 32'h0;
    forever begin
      @(negedge clk);
      mem_rvalid = 1'b0;
      mem_rdata  = 32'h0;
      if (pend) begin
        pend_cnt--;
        if (pend_cnt == 0) begin
          pend = 1'b0;
          mem_rvalid = 1'b1;
          mem_rdata = mem_dbase + {30'h0, pend_addr[3:2]};
        end
      end
      if (mem_rd_en) begin
        rd_log.push_back(mem_addr);
        pend = 1'b1;
        pend_cnt = mem_lat;
        pend_addr = mem_addr;
        if (spur_en) begin
          mem_rvalid = 1'b1;
          mem_rdata = 32'hDEAD_BEEF;
        end
      end
    end
  end

  // One refill: miss driven now (cycle 0), watched until fill_valid.
  task automatic run_refill(input logic [31:0] addr, input int lat, input bit spur,
                            input bit chg, input bit b2b, input int exp_fill,
                            input logic [31:0] dbase, input string nm);
    int          fill_cyc;
    bit          stall_ok;
    logic [31:0] base;
    logic [31:0] dv[4];
    logic [31:0] exp_a;
    base = addr & 32'hFFFF_FFF0;
    mem_lat = lat;
    spur_en = spur;
    mem_dbase = dbase;
    rd_log.delete();
    req_valid = 1'b1;
    req_hit = 1'b0;
    req_addr = addr;
    #1;
    checks++;
    if (stall !== 1'b1) begin
      failures++;
      $display("FAIL %s detect_stall: got %b expected 1", nm, stall);
    end
    fill_cyc = -1;
    stall_ok = 1'b1;
    for (int n = 1; n <= 80 && fill_cyc < 0; n++) begin
      @(negedge clk);
      if (chg && n == 3) req_addr = 32'hFFFF_FFF0;
      if (stall !== 1'b1) stall_ok = 1'b0;
      if (fill_valid === 1'b1) fill_cyc = n;
    end
    checks++;
    if (fill_cyc != exp_fill) begin
      failures++;
      $display("FAIL %s fill_cycle: got %0d expected %0d", nm, fill_cyc, exp_fill);
    end
    checks++;
    if (!stall_ok) begin
      failures++;
      $display("FAIL %s stall_while_busy: got 0 expected 1", nm);
    end
    checks++;
    if (fill_addr !== base) begin
      failures++;
      $display("FAIL %s fill_addr: got %h expected %h", nm, fill_addr, base);
    end
    dv = '{d0, d1, d2, d3};
    for (int k = 0; k < 4; k++) begin
      checks++;
      if (dv[k] !== dbase + k) begin
        failures++;
        $display("FAIL %s d%0d: got %h expected %h", nm, k, dv[k], dbase + k);
      end
    end
    checks++;
    if (rd_log.size() != 4) begin
      failures++;
      $display("FAIL %s read_count: got %0d expected 4", nm, rd_log.size());
    end
    for (int k = 0; k < 4 && k < rd_log.size(); k++) begin
      exp_a = base | (k << 2);
      checks++;
      if (rd_log[k] !== exp_a) begin
        failures++;
        $display("FAIL %s mem_addr%0d: got %h expected %h", nm, k, rd_log[k], exp_a);
      end
    end
    if (!b2b) begin
      req_hit = 1'b1;
      @(negedge clk);
      checks++;
      if (stall !== 1'b0 || busy !== 1'b0 || fill_valid !== 1'b0) begin
        failures++;
        $display("FAIL %s after_fill: got stall=%b busy=%b fill=%b expected 0 0 0",
                 nm, stall, busy, fill_valid);
      end
      req_valid = 1'b0;
      req_hit = 1'b0;
    end
  endtask

  task automatic test_reset;
    rst = 1'b1;
    req_valid = 1'b0;
    req_hit = 1'b0;
    req_addr = 32'h0;
    mem_lat = 1;
    spur_en = 1'b0;
    mem_dbase = 32'h0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    checks++;
    if (stall !== 1'b0 || busy !== 1'b0 || mem_rd_en !== 1'b0 || fill_valid !== 1'b0) begin
      failures++;
      $display("FAIL reset_ctrl: got stall=%b busy=%b rd=%b fill=%b expected 0 0 0 0",
               stall, busy, mem_rd_en, fill_valid);
    end
    checks++;
    if (mem_addr !== 32'h0 || fill_addr !== 32'h0) begin
      failures++;
      $display("FAIL reset_addr: got mem=%h fill=%h expected 0 0", mem_addr, fill_addr);
    end
    checks++;
    if ({d0, d1, d2, d3} !== 128'h0) begin
      failures++;
      $display("FAIL reset_line: got %h %h %h %h expected 0", d0, d1, d2, d3);
    end
  endtask

  task automatic test_hit;
    bit stall_seen, rd_seen, fill_seen, busy_seen;
    stall_seen = 1'b0;
    rd_seen = 1'b0;
    fill_seen = 1'b0;
    busy_seen = 1'b0;
    req_valid = 1'b1;
    req_hit = 1'b1;
    req_addr = 32'h0000_0040;
    for (int n = 0; n < 6; n++) begin
      #1;
      if (stall !== 1'b0) stall_seen = 1'b1;
      if (mem_rd_en !== 1'b0) rd_seen = 1'b1;
      if (fill_valid !== 1'b0) fill_seen = 1'b1;
      if (busy !== 1'b0) busy_seen = 1'b1;
      @(negedge clk);
    end
    checks++;
    if (stall_seen) begin failures++; $display("FAIL hit_stall: got 1 expected 0"); end
    checks++;
    if (rd_seen) begin failures++; $display("FAIL hit_rd_en: got 1 expected 0"); end
    checks++;
    if (fill_seen) begin failures++; $display("FAIL hit_fill: got 1 expected 0"); end
    checks++;
    if (busy_seen) begin failures++; $display("FAIL hit_busy: got 1 expected 0"); end
    req_valid = 1'b0;
    req_hit = 1'b0;
  endtask

  task automatic test_miss_basic;
    run_refill(32'h0000_1238, 1, 1'b0, 1'b0, 1'b0, 9, 32'h0000_00A0, "miss_l1");
  endtask

  task automatic test_spurious_rvalid;
    run_refill(32'h0000_0504, 3, 1'b1, 1'b0, 1'b0, 17, 32'h0000_00E0, "miss_l3_spur");
  endtask

  task automatic test_rst_mid;
    bit bad;
    mem_lat = 1;
    spur_en = 1'b0;
    mem_dbase = 32'h0000_00F0;
    rd_log.delete();
    req_valid = 1'b1;
    req_hit = 1'b0;
    req_addr = 32'h0000_1238;
    for (int n = 1; n <= 5; n++) @(negedge clk);
    rst = 1'b1;
    req_valid = 1'b0;
    @(negedge clk);
    checks++;
    if (busy !== 1'b0 || mem_rd_en !== 1'b0 || fill_valid !== 1'b0 || stall !== 1'b0) begin
      failures++;
      $display("FAIL rst_mid_idle: got busy=%b rd=%b fill=%b stall=%b expected 0 0 0 0",
               busy, mem_rd_en, fill_valid, stall);
    end
    rst = 1'b0;
    bad = 1'b0;
    for (int n = 0; n < 8; n++) begin
      @(negedge clk);
      if (fill_valid !== 1'b0 || busy !== 1'b0 || mem_rd_en !== 1'b0) bad = 1'b1;
    end
    checks++;
    if (bad) begin
      failures++;
      $display("FAIL rst_mid_quiet: got activity after abort expected none");
    end
    checks++;
    if ({d0, d1, d2, d3} !== 128'h0) begin
      failures++;
      $display("FAIL rst_mid_line: got %h %h %h %h expected 0", d0, d1, d2, d3);
    end
    run_refill(32'h0000_0080, 1, 1'b0, 1'b0, 1'b0, 9, 32'h0000_00C0, "after_rst");
  endtask

  task automatic test_busy_ignore;
    run_refill(32'h0000_1238, 1, 1'b0, 1'b1, 1'b0, 9, 32'h0000_00A0, "addr_change");
    run_refill(32'hFFFF_FFFC, 1, 1'b0, 1'b0, 1'b0, 9, 32'h0000_00B0, "top_line");
  endtask

  task automatic test_back_to_back;
    run_refill(32'h0000_2008, 1, 1'b0, 1'b0, 1'b1, 9, 32'h0000_0010, "b2b_first");
    run_refill(32'h0000_3004, 1, 1'b0, 1'b0, 1'b0, 10, 32'h0000_0020, "b2b_second");
  endtask

  initial begin
    checks = 0;
    failures = 0;
    test_reset();
    test_hit();
    test_miss_basic();
    test_spurious_rvalid();
    test_rst_mid();
    test_busy_ignore();
    test_back_to_back();
    repeat (2) @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
